// File: rtl/cat_chaser_if.sv
// Bundle between the Location block and the cat pursuit controller.
// Location (or a bench) drives positions/control; the chaser returns catDir.
interface cat_chaser_if;
    logic       enable;
    logic       game_over;
    logic [3:0] cat_x;
    logic [3:0] cat_y;
    logic [3:0] mouse_x;
    logic [3:0] mouse_y;
    logic [2:0] catDir;
    logic       blocked;
    logic [7:0] moves;

    modport master (
        output enable, game_over,
        output cat_x, cat_y, mouse_x, mouse_y,
        input  catDir, blocked, moves
    );

    modport slave (
        input  enable, game_over,
        input  cat_x, cat_y, mouse_x, mouse_y,
        output catDir, blocked, moves
    );
endinterface

// File: rtl/cat_chaser.sv
// Autonomous cat pursuit: paced steps toward the mouse, axis swap when blocked.
// Optional CAT_CHASER_RANDOM_EN adds an LFSR that breaks diagonal ties.
module cat_chaser #(
    parameter int TICK_DIV = 25000000,
    parameter int CNT_W    = 25
) (
    input logic         clock,
    input logic         reset,
    cat_chaser_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, WAIT, DECIDE, ISSUE, CHECK1, CHECK2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       dirR;
    logic [2:0]       codeR;
    logic [3:0]       beforeX;
    logic [3:0]       beforeY;
    logic             blkR;
    logic [7:0]       movesR;

    logic [4:0] dx;
    logic [4:0] dy;
    logic [4:0] ax;
    logic [4:0] ay;
    logic       tieY;
    logic       pickX;
    logic [2:0] code;
    logic       run;
    logic       samePos;

    assign bus.catDir  = dirR;
    assign bus.blocked = blkR;
    assign bus.moves   = movesR;

    // Two's complement deltas in 5 bits; 0..15 operands never overflow.
    assign dx = {1'b0, bus.mouse_x} - {1'b0, bus.cat_x};
    assign dy = {1'b0, bus.mouse_y} - {1'b0, bus.cat_y};
    assign ax = dx[4] ? (~dx + 5'd1) : dx;
    assign ay = dy[4] ? (~dy + 5'd1) : dy;

    assign run     = bus.enable && !bus.game_over;
    assign samePos = (bus.cat_x == beforeX) && (bus.cat_y == beforeY);

`ifdef CAT_CHASER_RANDOM_EN
    logic [7:0] lfsr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign tieY = lfsr[0];
`else
    assign tieY = 1'b0;
`endif

    always_comb begin
        pickX = (ax > ay) || ((ax == ay) && (ax != 5'd0) && !tieY);
        if (blkR) begin
            if (pickX && (dy != 5'd0)) begin
                pickX = 1'b0;
            end else if (!pickX && (dx != 5'd0)) begin
                pickX = 1'b1;
            end
        end
        code = 3'd0;
        if ((dx != 5'd0) || (dy != 5'd0)) begin
            if (pickX) begin
                code = dx[4] ? 3'd3 : 3'd4;
            end else begin
                code = dy[4] ? 3'd1 : 3'd2;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            dirR    <= 3'd0;
            codeR   <= 3'd0;
            beforeX <= 4'd0;
            beforeY <= 4'd0;
            blkR    <= 1'b0;
            movesR  <= 8'd0;
        end else if (!run) begin
            state <= IDLE;
            cnt   <= '0;
            blkR  <= 1'b0;
            dirR  <= 3'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (cnt == CNT_W'(TICK_DIV - 1)) begin
                        state <= DECIDE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DECIDE: begin
                    codeR   <= code;
                    dirR    <= code;
                    beforeX <= bus.cat_x;
                    beforeY <= bus.cat_y;
                    state   <= ISSUE;
                end
                ISSUE: begin
                    dirR <= 3'd0;
                    if ((codeR != 3'd0) && (movesR != 8'hFF)) begin
                        movesR <= movesR + 8'd1;
                    end
                    state <= CHECK1;
                end
                CHECK1: begin
                    state <= CHECK2;
                end
                CHECK2: begin
                    blkR  <= (codeR != 3'd0) && samePos;
                    cnt   <= '0;
                    state <= WAIT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cat_chaser.sv
// Scoreboard bench for cat_chaser: a Location stand-in moves the cat,
// a pursuit model predicts pulses, blocked and moves per step.
module tb_cat_chaser;

    localparam int TICK = 4;
    localparam int PER  = TICK + 4;

    typedef struct {
        int c;
        int d;
    } pulse_t;

    typedef struct {
        int c;
        bit b;
        int mv;
    } stat_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    cat_chaser_if bus ();

    cat_chaser #(
        .TICK_DIV(TICK),
        .CNT_W   (3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    pulse_t pq[$];
    stat_t  sq[$];

    int cx, cy, mx, my;
    bit blk;
    int movesM;
    int w;

    // Pursuit rule from the axis-choice description, default (no LFSR) build.
    function automatic int expDir(int acx, int acy, int amx, int amy, bit ablk);
        int ddx, ddy, aax, aay;
        bit useX;
        ddx = amx - acx;
        ddy = amy - acy;
        aax = ddx < 0 ? -ddx : ddx;
        aay = ddy < 0 ? -ddy : ddy;
        if (aax == 0 && aay == 0) return 0;
        useX = (aax >= aay);
        if (ablk) begin
            if (useX && ddy != 0) useX = 1'b0;
            else if (!useX && ddx != 0) useX = 1'b1;
        end
        if (useX) return ddx < 0 ? 3 : 4;
        return ddy < 0 ? 1 : 2;
    endfunction

    always @(negedge clock) begin
        int ed;
        stat_t s;
        ed = 0;
        if (pq.size() != 0 && pq[0].c == cyc) ed = pq.pop_front().d;
        checks++;
        if (bus.catDir !== 3'(ed)) begin
            failures++;
            $display("FAIL catDir cyc=%0d got=%0d exp=%0d", cyc, bus.catDir, ed);
        end
        if (sq.size() != 0 && sq[0].c == cyc) begin
            s = sq.pop_front();
            checks++;
            if (bus.blocked !== s.b) begin
                failures++;
                $display("FAIL blocked cyc=%0d got=%0d exp=%0d", cyc, bus.blocked, s.b);
            end
            checks++;
            if (bus.moves !== 8'(s.mv)) begin
                failures++;
                $display("FAIL moves cyc=%0d got=%0d exp=%0d", cyc, bus.moves, s.mv);
            end
        end
    end

    task automatic waitCyc(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic setPos(input int ncx, ncy, nmx, nmy);
        cx = ncx; cy = ncy; mx = nmx; my = nmy;
        bus.cat_x   = 4'(cx);
        bus.cat_y   = 4'(cy);
        bus.mouse_x = 4'(mx);
        bus.mouse_y = 4'(my);
    endtask

    task automatic pushStat(input int c, input bit b, input int mv);
        stat_t s;
        s.c = c; s.b = b; s.mv = mv;
        sq.push_back(s);
    endtask

    // One full step period starting at the negedge right after WAIT entry.
    task automatic step(input int ncx, ncy, nmx, nmy, input bit wall);
        int d;
        pulse_t p;
        setPos(ncx, ncy, nmx, nmy);
        d = expDir(cx, cy, mx, my, blk);
        if (d != 0) begin
            if (movesM < 255) movesM++;
            p.c = w + TICK + 1;
            p.d = d;
            pq.push_back(p);
        end
        waitCyc(w + TICK + 2);
        if (d != 0 && !wall) begin
            case (d)
                1: cy--;
                2: cy++;
                3: cx--;
                default: cx++;
            endcase
            setPos(cx, cy, mx, my);
        end
        blk = (d != 0) && wall;
        pushStat(w + PER, blk, movesM);
        waitCyc(w + PER);
        w += PER;
    endtask

    task automatic rndStep();
        int ncx, ncy, nmx, nmy, r;
        ncx = cx; ncy = cy; nmx = mx; nmy = my;
        r = $urandom_range(0, 7);
        if (r == 0) begin
            ncx = $urandom_range(0, 15);
            ncy = $urandom_range(0, 15);
        end
        if (r < 4) begin
            nmx = $urandom_range(0, 15);
            nmy = $urandom_range(0, 15);
        end
        if (r == 7) begin
            nmx = ncx;
            nmy = ncy;
        end
        step(ncx, ncy, nmx, nmy, $urandom_range(0, 2) == 0);
    endtask

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog cyc=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        blk = 1'b0;
        movesM = 0;
        bus.enable = 1'b0;
        bus.game_over = 1'b0;
        setPos(0, 0, 0, 0);
        #1 reset = 1'b0;
        pushStat(1, 1'b0, 0);
        pushStat(2, 1'b0, 0);
        pushStat(3, 1'b0, 0);
        repeat (3) begin
            bus.enable = 1'($urandom_range(0, 1));
            bus.game_over = 1'($urandom_range(0, 1));
            setPos($urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 15));
            @(negedge clock);
        end
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.game_over = 1'b0;
        @(negedge clock);
        bus.enable = 1'b1;
        w = cyc + 1;
        waitCyc(w);

        step(2, 2, 7, 3, 1'b0);
        step(cx, cy, 7, 3, 1'b0);
        step(5, 9, 5, 4, 1'b0);
        step(cx, cy, 5, 4, 1'b0);
        repeat (5) step(6, 6, 6, 6, 1'b0);
        step(2, 2, 7, 5, 1'b1);
        step(2, 2, 7, 5, 1'b1);
        step(2, 2, 7, 5, 1'b0);
        step(4, 4, 9, 4, 1'b1);

        waitCyc(w + 1);
        bus.game_over = 1'b1;
        blk = 1'b0;
        pushStat(w + 6, 1'b0, movesM);
        waitCyc(w + 6);
        setPos(0, 0, 3, 3);
        bus.game_over = 1'b0;
        w = w + 7;
        waitCyc(w);
        step(0, 0, 3, 3, 1'b0);

        repeat (300) rndStep();

        setPos(1, 1, 9, 1);
        waitCyc(w + TICK);
        @(posedge clock);
        #1 reset = 1'b0;
        blk = 1'b0;
        movesM = 0;
        pushStat(w + TICK + 1, 1'b0, 0);
        pushStat(w + TICK + 2, 1'b0, 0);
        waitCyc(w + TICK + 3);
        reset = 1'b1;
        waitCyc(cyc + 3);

        checks++;
        if (pq.size() != 0) begin
            failures++;
            $display("FAIL pulseQ left=%0d exp=0", pq.size());
        end
        checks++;
        if (sq.size() != 0) begin
            failures++;
            $display("FAIL statQ left=%0d exp=0", sq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cat_chaser.md
# cat_chaser

Autonomous pursuit controller for the cat sprite. It reads the current cat and mouse grid positions from the Location block and produces the cat direction code that Location consumes. A fixed step period sets the pace. A blocked-move detector switches the cat to its other axis when a step has no effect. It sits between Location's position outputs and its catDir input, replacing the player-2 button path in single-player builds.

## Interface
Parameters:
- TICK_DIV, default 25000000: WAIT-state length in clock cycles (≥1); sets the cat step rate.
- CNT_W, default 25: width of the tick counter; must hold TICK_DIV-1.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  high lets the chaser run; low forces IDLE.
- game_over  in  1  Location's GameOver; high forces IDLE.
- cat_x, cat_y  in  4 each  current cat position.
- mouse_x, mouse_y  in  4 each  current mouse position.
- catDir  out  3  direction code: 0 stay, 1 up (Y-1), 2 down (Y+1), 3 left (X-1), 4 right (X+1).
- blocked  out  1  last issued step did not change the cat position.
- moves  out  8  count of nonzero steps issued; saturates at 255.

## Operation
- States: IDLE, WAIT, DECIDE, ISSUE, CHECK1, CHECK2.
- IDLE -> WAIT when enable=1 and game_over=0; the tick counter is cleared on entry to WAIT.
- WAIT counts 0..TICK_DIV-1, then goes to DECIDE.
- DECIDE computes a signed 5-bit dx = mouse_x - cat_x and dy = mouse_y - cat_y, registers the chosen code, and latches cat_x and cat_y as the "before" position.
- Axis choice:
  - |dx|>|dy| selects the X axis; |dy|>|dx| selects the Y axis.
  - A tie with both deltas nonzero selects X.
  - If blocked=1 and the other axis delta is nonzero, the axis is swapped.
  - dx=dy=0 produces code 0.
- ISSUE drives the registered code on catDir for exactly one cycle. If the code is nonzero, moves increments, saturating at 255.
- CHECK1 and CHECK2 give Location two cycles to update the position. At the end of CHECK2:
  - if a nonzero code was issued and cat_x/cat_y equal the "before" position, blocked is set to 1;
  - otherwise blocked is set to 0.
  - The state then returns to WAIT.
- catDir is 0 in every state except ISSUE.
- If enable=0 or game_over=1 is sampled in any state, the next state is IDLE: counter cleared, blocked cleared, catDir=0. moves is held, not cleared.
- DECIDE never advances to ISSUE while game_over=1.

## Timing
- Reset values: state IDLE, counter 0, catDir 0, blocked 0, moves 0, "before" position 0, LFSR 8'hA5.
- Registered outputs only; nothing is combinational from input to output.
- Step period is TICK_DIV+4 cycles: TICK_DIV in WAIT, plus DECIDE, ISSUE, CHECK1, CHECK2.
- First pulse: catDir becomes nonzero TICK_DIV+1 cycles after the edge that enters WAIT.
- Position inputs are sampled only in DECIDE and at the end of CHECK2. Changes at any other time have no effect.
- Reset asserted mid-operation immediately returns all outputs to their reset values, including an in-flight ISSUE pulse.
- Coordinate wrap: the deltas are signed 5-bit values, so 0..15 never overflows.

## Configuration
- CAT_CHASER_RANDOM_EN: when defined, an 8-bit Fibonacci LFSR is included.
  - Taps are 8,6,5,4; the register advances every clock outside reset.
  - On a tie (|dx|=|dy|≠0), LFSR bit 0 selects the axis: 0 selects X, 1 selects Y.
- When not defined, there is no LFSR and a tie always selects X.

## Test plan
All scenarios use TICK_DIV=4.
- Reset: hold reset=0 for 3 cycles with random inputs -> catDir=0, blocked=0, moves=0 throughout.
- Pursuit X: cat (2,2), mouse (7,3), enable=1 -> catDir=4 for one cycle, 5 cycles after WAIT entry. Pulses repeat every 8 cycles; moves increments 0->1->2.
- Pursuit Y: cat (5,9), mouse (5,4) -> catDir=1 each period.
- Caught: cat (6,6), mouse (6,6) -> catDir stays 0 and moves is unchanged over 40 cycles.
- Blocked swap: cat held at (2,2), mouse (7,5):
  - first pulse catDir=4, then blocked=1 after CHECK2;
  - next pulse catDir=2;
  - move the cat to (2,3) -> blocked=0 after CHECK2.
- Abort/tie (macro undefined): game_over=1 during WAIT -> no pulse and moves held. Deassert with cat (0,0), mouse (3,3) -> catDir=4 after a full TICK_DIV+1 cycles.
